// File: rtl/conv_frame_assembler_pkg.sv
// Shared constants and FSM encoding for the convolutional frame assembler.
// Latency: n/a (package only). Backpressure: n/a.
// Optional error-inject feature in the users of this package: CONV_FRAME_ERR_INJECT_EN.
package conv_frame_assembler_pkg;

    localparam int MAX_CODE_RATE   = 2;
    localparam int TRACEBACK_DEPTH = 16;

    typedef enum logic {
        ST_FILL = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

endpackage

// File: rtl/conv_frame_outreg.sv
// Output frame register with valid/ready hold; optional bit flip on load (CONV_FRAME_ERR_INJECT_EN).
// Latency: 1 cycle from load to frame_vld.
// Backpressure: data/pad held stable while frame_vld & !frame_rdy; load only when free or accepting.
module conv_frame_outreg
    import conv_frame_assembler_pkg::*;
#(
    parameter int FRAME_BITS = TRACEBACK_DEPTH
) (
    input  logic                          sys_clk,
    input  logic                          rst,
    input  logic                          en,
    input  logic                          load,
    input  logic [FRAME_BITS-1:0]         load_dat,
    input  logic                          load_pad,
`ifdef CONV_FRAME_ERR_INJECT_EN
    input  logic                          err_inject,
    input  logic [$clog2(FRAME_BITS)-1:0] err_pos,
`endif
    input  logic                          frame_rdy,
    output logic [FRAME_BITS-1:0]         frame_dat,
    output logic                          frame_vld,
    output logic                          frame_pad
);

    logic [FRAME_BITS-1:0] err_mask;

    always_comb begin
        err_mask = '0;
`ifdef CONV_FRAME_ERR_INJECT_EN
        if (err_inject) err_mask[err_pos] = 1'b1;
`endif
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            frame_dat <= '0;
            frame_vld <= 1'b0;
            frame_pad <= 1'b0;
        end else if (en) begin
            if (load) begin
                frame_dat <= load_dat ^ err_mask;
                frame_vld <= 1'b1;
                frame_pad <= load_pad;
            end else if (frame_vld && frame_rdy) begin
                frame_vld <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/conv_frame_assembler.sv
// Packs CODE_RATE-bit symbols MSB-first into FRAME_BITS frames; flush closes a zero-padded partial frame.
// Latency: frame valid 1 cycle after the last symbol (or flush). Optional macro: CONV_FRAME_ERR_INJECT_EN.
// Backpressure: a full frame waits in the assembly register (o_sym_ready=0) until the output register frees.
module conv_frame_assembler
    import conv_frame_assembler_pkg::*;
#(
    parameter int CODE_RATE  = MAX_CODE_RATE,
    parameter int FRAME_BITS = TRACEBACK_DEPTH
) (
    input  logic                          sys_clk,
    input  logic                          rst,
    input  logic                          en,
    input  logic [CODE_RATE-1:0]          i_sym_data,
    input  logic                          i_sym_valid,
    output logic                          o_sym_ready,
    input  logic                          i_flush,
`ifdef CONV_FRAME_ERR_INJECT_EN
    input  logic                          i_err_inject,
    input  logic [$clog2(FRAME_BITS)-1:0] i_err_pos,
`endif
    output logic [FRAME_BITS-1:0]         o_frame_data,
    output logic                          o_frame_valid,
    input  logic                          i_frame_ready,
    output logic                          o_frame_padded
);

    localparam int SYMS  = FRAME_BITS / CODE_RATE;
    localparam int CNT_W = $clog2(SYMS + 1);

    state_t                state, state_nxt;
    logic [CNT_W-1:0]      cnt, cnt_nxt;
    logic [FRAME_BITS-1:0] asm_dat, asm_nxt;
    logic                  pad_hold, pad_nxt;
    logic                  sym_acc, last_sym, complete, out_free;
    logic                  load, load_pad;
    logic [FRAME_BITS-1:0] load_dat, sym_word, fill_dat;

    assign o_sym_ready = !rst && (state == ST_FILL);
    assign sym_acc     = en && i_sym_valid && o_sym_ready;
    assign last_sym    = sym_acc && (cnt == CNT_W'(SYMS - 1));
    assign complete    = en && (state == ST_FILL) &&
                         (last_sym || (i_flush && ((cnt != '0) || sym_acc)));
    assign out_free    = !o_frame_valid || i_frame_ready;

    // Assembly register is zeroed after every transfer, so unfilled slots are already the pad value.
    always_comb begin
        sym_word = '0;
        sym_word[FRAME_BITS-1 -: CODE_RATE] = i_sym_data;
        fill_dat = sym_acc ? (asm_dat | (sym_word >> (cnt * CODE_RATE))) : asm_dat;
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        asm_nxt   = asm_dat;
        pad_nxt   = pad_hold;
        load      = 1'b0;
        load_dat  = asm_dat;
        load_pad  = pad_hold;
        case (state)
            ST_FILL: begin
                if (complete) begin
                    cnt_nxt = '0;
                    if (out_free) begin
                        load     = 1'b1;
                        load_dat = fill_dat;
                        load_pad = !last_sym;
                        asm_nxt  = '0;
                    end else begin
                        state_nxt = ST_WAIT;
                        asm_nxt   = fill_dat;
                        pad_nxt   = !last_sym;
                    end
                end else if (sym_acc) begin
                    asm_nxt = fill_dat;
                    cnt_nxt = cnt + 1'b1;
                end
            end
            ST_WAIT: begin
                if (en && out_free) begin
                    load      = 1'b1;
                    asm_nxt   = '0;
                    cnt_nxt   = '0;
                    state_nxt = ST_FILL;
                end
            end
            default: state_nxt = ST_FILL;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state    <= ST_FILL;
            cnt      <= '0;
            asm_dat  <= '0;
            pad_hold <= 1'b0;
        end else if (en) begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            asm_dat  <= asm_nxt;
            pad_hold <= pad_nxt;
        end
    end

    conv_frame_outreg #(
        .FRAME_BITS (FRAME_BITS)
    ) u_outreg (
        .sys_clk    (sys_clk),
        .rst        (rst),
        .en         (en),
        .load       (load),
        .load_dat   (load_dat),
        .load_pad   (load_pad),
`ifdef CONV_FRAME_ERR_INJECT_EN
        .err_inject (i_err_inject),
        .err_pos    (i_err_pos),
`endif
        .frame_rdy  (i_frame_ready),
        .frame_dat  (o_frame_data),
        .frame_vld  (o_frame_valid),
        .frame_pad  (o_frame_padded)
    );

endmodule

// File: tb/tb_conv_frame_assembler.sv
// Testbench for conv_frame_assembler: directed scenarios plus a randomized run against a frame-queue model.
// Optional CONV_FRAME_ERR_INJECT_EN adds the error-inject scenario.
module tb_conv_frame_assembler;

    localparam int CR   = 2;
    localparam int FB   = 16;
    localparam int SYMS = FB / CR;

    logic          sys_clk = 1'b0;
    logic          rst = 1'b1;
    logic          en = 1'b1;
    logic [CR-1:0] i_sym_data = '0;
    logic          i_sym_valid = 1'b0;
    logic          i_flush = 1'b0;
    logic          i_frame_ready = 1'b0;
    logic          o_sym_ready;
    logic [FB-1:0] o_frame_data;
    logic          o_frame_valid;
    logic          o_frame_padded;
`ifdef CONV_FRAME_ERR_INJECT_EN
    logic          i_err_inject = 1'b0;
    logic [3:0]    i_err_pos = '0;
`endif

    always #5 sys_clk = ~sys_clk;

    conv_frame_assembler #(.CODE_RATE(CR), .FRAME_BITS(FB)) dut (
        .sys_clk        (sys_clk),
        .rst            (rst),
        .en             (en),
        .i_sym_data     (i_sym_data),
        .i_sym_valid    (i_sym_valid),
        .o_sym_ready    (o_sym_ready),
        .i_flush        (i_flush),
`ifdef CONV_FRAME_ERR_INJECT_EN
        .i_err_inject   (i_err_inject),
        .i_err_pos      (i_err_pos),
`endif
        .o_frame_data   (o_frame_data),
        .o_frame_valid  (o_frame_valid),
        .i_frame_ready  (i_frame_ready),
        .o_frame_padded (o_frame_padded)
    );

    int vectors = 0;
    int miscompares = 0;

    // Reference: symbols of the open frame, and completed frames not yet taken by the decoder.
    logic [CR-1:0] cur_syms[$];
    logic [FB-1:0] exp_dat[$];
    logic          exp_pad[$];

    function automatic logic [FB-1:0] pack(input logic [CR-1:0] s[$]);
        logic [FB-1:0] f = '0;
        for (int i = 0; i < s.size(); i++) f[FB-1-CR*i -: CR] = s[i];
        return f;
    endfunction

    task automatic clk_cycle();
        #1;
        if (rst) begin
            cur_syms.delete();
            exp_dat.delete();
            exp_pad.delete();
        end else if (en) begin
            if (o_frame_valid && i_frame_ready && exp_dat.size() > 0) begin
                void'(exp_dat.pop_front());
                void'(exp_pad.pop_front());
            end
            if (i_sym_valid && o_sym_ready) cur_syms.push_back(i_sym_data);
            if (o_sym_ready && (cur_syms.size() == SYMS || (i_flush && cur_syms.size() > 0))) begin
                exp_dat.push_back(pack(cur_syms));
                exp_pad.push_back(cur_syms.size() < SYMS);
                cur_syms.delete();
            end
        end
        @(posedge sys_clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [CR-1:0] d, input logic f);
        i_sym_valid = v;
        i_sym_data  = d;
        i_flush     = f;
        clk_cycle();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(0, 0, 0);
        vectors += 4;
        if (o_frame_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid got=%b want=0", o_frame_valid); end
        if (o_frame_data !== '0) begin miscompares++; $display("FAIL reset_data got=%h want=0000", o_frame_data); end
        if (o_frame_padded !== 1'b0) begin miscompares++; $display("FAIL reset_pad got=%b want=0", o_frame_padded); end
        if (o_sym_ready !== 1'b0) begin miscompares++; $display("FAIL reset_ready got=%b want=0", o_sym_ready); end
        rst = 1'b0;
        drive(0, 0, 0);
        vectors++;
        if (o_sym_ready !== 1'b1) begin miscompares++; $display("FAIL post_reset_ready got=%b want=1", o_sym_ready); end
    endtask

    task automatic test_basic_pack();
        logic [CR-1:0] s[8] = '{2'b11, 2'b10, 2'b00, 2'b01, 2'b11, 2'b01, 2'b10, 2'b00};
        i_frame_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            drive(1, s[k], 0);
            if (k < 7) begin
                vectors++;
                if (o_frame_valid !== 1'b0) begin miscompares++; $display("FAIL basic_early_valid k=%0d got=%b want=0", k, o_frame_valid); end
            end
        end
        vectors += 3;
        if (o_frame_valid !== 1'b1) begin miscompares++; $display("FAIL basic_valid got=%b want=1", o_frame_valid); end
        if (o_frame_data !== 16'b1110000111011000) begin miscompares++; $display("FAIL basic_data got=%b want=1110000111011000", o_frame_data); end
        if (o_frame_padded !== 1'b0) begin miscompares++; $display("FAIL basic_pad got=%b want=0", o_frame_padded); end
        drive(0, 0, 0);
        vectors++;
        if (o_frame_valid !== 1'b0) begin miscompares++; $display("FAIL basic_drain got=%b want=0", o_frame_valid); end
    endtask

    task automatic test_back_to_back();
        logic [CR-1:0] q1[$];
        logic [CR-1:0] q2[$];
        logic [CR-1:0] d;
        i_frame_ready = 1'b0;
        for (int k = 0; k < 16; k++) begin
            d = CR'($urandom);
            if (k < 8) q1.push_back(d); else q2.push_back(d);
            drive(1, d, 0);
            if (k == 7) begin
                vectors += 2;
                if (o_frame_valid !== 1'b1) begin miscompares++; $display("FAIL bp_first_valid got=%b want=1", o_frame_valid); end
                if (o_frame_data !== pack(q1)) begin miscompares++; $display("FAIL bp_first_data got=%h want=%h", o_frame_data, pack(q1)); end
            end
        end
        for (int k = 0; k < 3; k++) begin
            vectors += 3;
            if (o_sym_ready !== 1'b0) begin miscompares++; $display("FAIL bp_wait_ready c=%0d got=%b want=0", k, o_sym_ready); end
            if (o_frame_valid !== 1'b1) begin miscompares++; $display("FAIL bp_hold_valid c=%0d got=%b want=1", k, o_frame_valid); end
            if (o_frame_data !== pack(q1)) begin miscompares++; $display("FAIL bp_hold_data c=%0d got=%h want=%h", k, o_frame_data, pack(q1)); end
            drive(1, CR'($urandom), 0);
        end
        i_frame_ready = 1'b1;
        drive(0, 0, 0);
        vectors += 3;
        if (o_frame_valid !== 1'b1) begin miscompares++; $display("FAIL bp_second_valid got=%b want=1", o_frame_valid); end
        if (o_frame_data !== pack(q2)) begin miscompares++; $display("FAIL bp_second_data got=%h want=%h", o_frame_data, pack(q2)); end
        if (o_sym_ready !== 1'b1) begin miscompares++; $display("FAIL bp_ready_back got=%b want=1", o_sym_ready); end
        drive(0, 0, 0);
        vectors++;
        if (o_frame_valid !== 1'b0) begin miscompares++; $display("FAIL bp_drain got=%b want=0", o_frame_valid); end
    endtask

    task automatic test_flush();
        i_frame_ready = 1'b1;
        drive(1, 2'b11, 0);
        drive(1, 2'b01, 0);
        drive(1, 2'b10, 0);
        drive(0, 0, 1);
        vectors += 3;
        if (o_frame_valid !== 1'b1) begin miscompares++; $display("FAIL flush_valid got=%b want=1", o_frame_valid); end
        if (o_frame_data !== 16'b1101100000000000) begin miscompares++; $display("FAIL flush_data got=%b want=1101100000000000", o_frame_data); end
        if (o_frame_padded !== 1'b1) begin miscompares++; $display("FAIL flush_pad got=%b want=1", o_frame_padded); end
        drive(0, 0, 0);
        drive(0, 0, 1);
        vectors++;
        if (o_frame_valid !== 1'b0) begin miscompares++; $display("FAIL flush_empty got=%b want=0", o_frame_valid); end
        drive(0, 0, 0);
    endtask

    task automatic test_flush_last();
        logic [CR-1:0] q[$];
        logic [CR-1:0] d;
        i_frame_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            d = CR'($urandom);
            q.push_back(d);
            drive(1, d, k == 7);
        end
        vectors += 3;
        if (o_frame_valid !== 1'b1) begin miscompares++; $display("FAIL flast_valid got=%b want=1", o_frame_valid); end
        if (o_frame_data !== pack(q)) begin miscompares++; $display("FAIL flast_data got=%h want=%h", o_frame_data, pack(q)); end
        if (o_frame_padded !== 1'b0) begin miscompares++; $display("FAIL flast_pad got=%b want=0", o_frame_padded); end
        drive(0, 0, 0);
    endtask

    task automatic test_reset_mid_frame();
        i_frame_ready = 1'b0;
        for (int k = 0; k < 13; k++) drive(1, CR'($urandom), 0);
        rst = 1'b1;
        drive(0, 0, 0);
        vectors += 4;
        if (o_frame_valid !== 1'b0) begin miscompares++; $display("FAIL rmid_valid got=%b want=0", o_frame_valid); end
        if (o_frame_data !== '0) begin miscompares++; $display("FAIL rmid_data got=%h want=0000", o_frame_data); end
        if (o_frame_padded !== 1'b0) begin miscompares++; $display("FAIL rmid_pad got=%b want=0", o_frame_padded); end
        if (o_sym_ready !== 1'b0) begin miscompares++; $display("FAIL rmid_ready got=%b want=0", o_sym_ready); end
        rst = 1'b0;
        i_frame_ready = 1'b1;
        for (int k = 0; k < 8; k++) drive(1, 2'b01, 0);
        vectors += 3;
        if (o_frame_valid !== 1'b1) begin miscompares++; $display("FAIL rmid_new_valid got=%b want=1", o_frame_valid); end
        if (o_frame_data !== 16'h5555) begin miscompares++; $display("FAIL rmid_new_data got=%h want=5555", o_frame_data); end
        if (o_frame_padded !== 1'b0) begin miscompares++; $display("FAIL rmid_new_pad got=%b want=0", o_frame_padded); end
        drive(0, 0, 0);
    endtask

    task automatic test_en_freeze();
        logic [CR-1:0] q[$];
        logic [CR-1:0] d;
        i_frame_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin d = CR'($urandom); q.push_back(d); drive(1, d, 0); end
        en = 1'b0;
        for (int k = 0; k < 2; k++) begin
            drive(1, CR'($urandom), 1);
            vectors += 2;
            if (o_sym_ready !== 1'b1) begin miscompares++; $display("FAIL en_ready c=%0d got=%b want=1", k, o_sym_ready); end
            if (o_frame_valid !== 1'b0) begin miscompares++; $display("FAIL en_no_frame c=%0d got=%b want=0", k, o_frame_valid); end
        end
        en = 1'b1;
        for (int k = 0; k < 5; k++) begin d = CR'($urandom); q.push_back(d); drive(1, d, 0); end
        vectors += 3;
        if (o_frame_valid !== 1'b1) begin miscompares++; $display("FAIL en_valid got=%b want=1", o_frame_valid); end
        if (o_frame_data !== pack(q)) begin miscompares++; $display("FAIL en_data got=%h want=%h", o_frame_data, pack(q)); end
        if (o_frame_padded !== 1'b0) begin miscompares++; $display("FAIL en_pad got=%b want=0", o_frame_padded); end
        en = 1'b0;
        drive(0, 0, 0);
        drive(0, 0, 0);
        vectors++;
        if (o_frame_valid !== 1'b1) begin miscompares++; $display("FAIL en_hold_valid got=%b want=1", o_frame_valid); end
        en = 1'b1;
        drive(0, 0, 0);
        vectors++;
        if (o_frame_valid !== 1'b0) begin miscompares++; $display("FAIL en_release got=%b want=0", o_frame_valid); end
    endtask

`ifdef CONV_FRAME_ERR_INJECT_EN
    task automatic test_err_inject();
        logic [CR-1:0] s[8] = '{2'b11, 2'b10, 2'b00, 2'b01, 2'b11, 2'b01, 2'b10, 2'b00};
        i_frame_ready = 1'b1;
        i_err_inject  = 1'b1;
        i_err_pos     = 4'd0;
        for (int k = 0; k < 8; k++) drive(1, s[k], 0);
        vectors += 2;
        if (o_frame_valid !== 1'b1) begin miscompares++; $display("FAIL inj_valid got=%b want=1", o_frame_valid); end
        if (o_frame_data !== 16'b1110000111011001) begin miscompares++; $display("FAIL inj_data got=%b want=1110000111011001", o_frame_data); end
        i_err_inject = 1'b0;
        drive(0, 0, 0);
    endtask
`endif

    task automatic test_random();
        for (int c = 0; c < 3000; c++) begin
            en            = ($urandom_range(0, 9) != 0);
            i_frame_ready = ($urandom_range(0, 9) < 6);
            drive($urandom_range(0, 9) < 7, CR'($urandom), $urandom_range(0, 11) == 0);
            vectors += 2;
            if (o_sym_ready !== (exp_dat.size() < 2)) begin
                miscompares++; $display("FAIL rand_ready c=%0d got=%b want=%b", c, o_sym_ready, exp_dat.size() < 2);
            end
            if (o_frame_valid !== (exp_dat.size() > 0)) begin
                miscompares++; $display("FAIL rand_valid c=%0d got=%b want=%b", c, o_frame_valid, exp_dat.size() > 0);
            end
            if (exp_dat.size() > 0) begin
                vectors += 2;
                if (o_frame_data !== exp_dat[0]) begin
                    miscompares++; $display("FAIL rand_data c=%0d got=%h want=%h", c, o_frame_data, exp_dat[0]);
                end
                if (o_frame_padded !== exp_pad[0]) begin
                    miscompares++; $display("FAIL rand_pad c=%0d got=%b want=%b", c, o_frame_padded, exp_pad[0]);
                end
            end
        end
        en = 1'b1;
        i_frame_ready = 1'b1;
        for (int k = 0; k < 4; k++) drive(0, 0, 0);
        vectors++;
        if (o_frame_valid !== 1'b0) begin miscompares++; $display("FAIL rand_drain got=%b want=0", o_frame_valid); end
    endtask

    initial begin
        test_reset();
        test_basic_pack();
        test_back_to_back();
        test_flush();
        test_flush_last();
        test_reset_mid_frame();
        test_en_freeze();
`ifdef CONV_FRAME_ERR_INJECT_EN
        test_err_inject();
`endif
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/conv_frame_assembler.md
Name: conv_frame_assembler

Overview:
- Receive-side counterpart to the convolutional encoder output.
- Collects CODE_RATE-bit encoded symbols, one per accepted cycle, and packs them into FRAME_BITS-wide frames for the Viterbi decoder's i_decoder_data_frame input.
- Double-buffered: one assembly register plus one output register, with valid/ready handshakes on both sides.
- Sits between the encoder (or channel model) and the decoder in the endec datapath.

Parameters:
- CODE_RATE, 2: bits per encoded symbol; matches MAX_CODE_RATE.
- FRAME_BITS, 16: output frame width; matches TRACEBACK_DEPTH. Must be a multiple of CODE_RATE.
- SYMS (localparam): FRAME_BITS/CODE_RATE, symbols per frame.

Ports:
- sys_clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  clock enable; when low, all state holds and no handshake completes.
- i_sym_data  in  CODE_RATE  encoded symbol.
- i_sym_valid  in  1  symbol present.
- o_sym_ready  out  1  assembler can accept a symbol.
- i_flush  in  1  close a partial frame, zero-padded.
- o_frame_data  out  FRAME_BITS  packed frame.
- o_frame_valid  out  1  frame available.
- i_frame_ready  in  1  decoder accepts the frame.
- o_frame_padded  out  1  the current output frame was closed by a flush.

Behaviour:
- Reset: state=ST_FILL, symbol count=0, assembly register=0, o_frame_data=0, o_frame_valid=0, o_frame_padded=0, o_sym_ready=0 during reset, then 1.
- Symbol accept: en & i_sym_valid & o_sym_ready.
- Frame accept: en & o_frame_valid & i_frame_ready.
- Packing: the first symbol of a frame lands in bits [FRAME_BITS-1 -: CODE_RATE]; each later symbol lands at the next lower slot. Bit order inside a symbol is preserved.
- ST_FILL: o_sym_ready=1. Count increments on each accept.
  - On the SYMS-th accept: if the output register is empty, or is being accepted in the same cycle, the frame transfers. o_frame_valid rises the next cycle (latency 1 from last symbol) and count returns to 0.
  - Otherwise the FSM goes to ST_WAIT.
- ST_WAIT: o_sym_ready=0. The assembly register holds a complete frame. Transfer happens on the first cycle the output register is empty or a frame accept occurs, then the FSM returns to ST_FILL with count=0.
- Output register: o_frame_data and o_frame_padded are stable while o_frame_valid=1 and not accepted. o_frame_valid clears after an accept unless a new transfer occurs in the same cycle (back-to-back frames, no bubble).
- Flush:
  - In ST_FILL with count>0 (counting a symbol accepted in the same cycle): unfilled slots become 0 and the frame completes this edge, following the same transfer/ST_WAIT rule; that frame carries padded=1.
  - In ST_FILL with count=0 and no accept: ignored.
  - In ST_WAIT: ignored.
- Simultaneous: a flush together with the SYMS-th symbol gives a full frame with padded=0.
- Reset mid-frame: partial data is discarded, and any pending output frame is dropped (o_frame_valid=0 next cycle).
- en low: frame accepts and symbol accepts are masked. o_sym_ready and o_frame_valid keep their values.

Optional Feature:
- Macro: CONV_FRAME_ERR_INJECT_EN.
- With it defined:
  - Added inputs: i_err_inject (1) and i_err_pos ($clog2(FRAME_BITS)).
  - At the transfer edge, if i_err_inject=1, bit i_err_pos of the frame is inverted before loading the output register. This models a channel bit error for decoder testing.
- Without it: the ports do not exist and frames pass unmodified.

Decomposition:
- Shared package (param_def.v include): MAX_CODE_RATE, TRACEBACK_DEPTH and the ST_FILL/ST_WAIT state encodings. Add DATA_FRAME_LENGTH only if shared.
- One natural sub-module: conv_frame_outreg (output register plus valid/ready holding logic, with the inject XOR).

Test Plan (CODE_RATE=2, FRAME_BITS=16):
- Basic pack: i_frame_ready=1; symbols 11,10,00,01,11,01,10,00 on consecutive cycles -> o_frame_data=16'b1110000111011000, o_frame_valid=1 one cycle after the 8th symbol, o_frame_padded=0.
- Backpressure: i_frame_ready=0; send 16 symbols -> first frame held stable, o_sym_ready=0 after the 16th symbol. Raise i_frame_ready -> second frame appears the next cycle with no bubble, and o_sym_ready returns to 1.
- Flush: symbols 11,01,10 then i_flush=1 -> o_frame_data=16'b1101100000000000, o_frame_padded=1. A flush with count=0 produces no frame.
- Flush with the last symbol: flush asserted with the 8th symbol -> full frame, o_frame_padded=0.
- Reset mid-frame: 5 symbols accepted, then rst=1 for 1 cycle -> all outputs 0; the next 8 symbols 01x8 give o_frame_data=16'h5555.
- With CONV_FRAME_ERR_INJECT_EN: i_err_inject=1, i_err_pos=0 on the basic-pack frame -> o_frame_data=16'b1110000111011001. Toggling en=0 mid-frame freezes count and data for those cycles.
